// File: rtl/decoder_arbiter.sv
// Round-robin arbiter that grants one of four requesters access to an external
// one-hot decoder, checks mode/code legality and returns the registered result.
module decoder_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [7:0]  mode_in,
    input  logic [15:0] code_in,
    output logic [3:0]  ack,
    output logic        dec_E,
    output logic [1:0]  dec_Z,
    output logic [3:0]  dec_X,
    input  logic [15:0] dec_Y,
    output logic [15:0] y_out,
    output logic        y_valid,
    output logic [1:0]  y_id,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]  id_q, id_d;
    logic        rej_q, rej_d;
    logic [15:0] y_out_q, y_out_d;
    logic [1:0]  y_id_q, y_id_d;
    logic        dec_e_q, dec_e_d;
    logic [1:0]  dec_z_q, dec_z_d;
    logic [3:0]  dec_x_q, dec_x_d;

    logic [3:0]  req_rot;
    logic [1:0]  mode_arr [4];
    logic [3:0]  code_arr [4];
    logic        grant_found;
    logic [1:0]  grant_off;
    logic [1:0]  grant_id;
    logic [1:0]  mode_sel;
    logic [3:0]  code_sel;
    logic        grant_legal;

    // req_rot[k] is the request of requester (rr_ptr + k) mod 4, so the lowest
    // set bit of req_rot is the round-robin winner.
    for (genvar gi = 0; gi < 4; gi++) begin : g_req
        logic [1:0] src;
        assign src         = rr_ptr_q + 2'(gi);
        assign req_rot[gi] = req[src];
        assign mode_arr[gi] = mode_in[2*gi+1:2*gi];
        assign code_arr[gi] = code_in[4*gi+3:4*gi];
        assign ack[gi]      = (state_q == RESP) && (id_q == 2'(gi));
    end

    always_comb begin
        grant_found = 1'b0;
        grant_off   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_found = 1'b1;
                grant_off   = 2'(k);
            end
        end
    end

    assign grant_id = rr_ptr_q + grant_off;
    assign mode_sel = mode_arr[grant_id];
    assign code_sel = code_arr[grant_id];

    always_comb begin
        unique case (mode_sel)
            2'b00:   grant_legal = (code_sel[3:2] == 2'b00);
            2'b01:   grant_legal = (code_sel[3] == 1'b0);
            2'b10:   grant_legal = 1'b1;
            default: grant_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        rej_d    = rej_q;
        y_out_d  = y_out_q;
        y_id_d   = y_id_q;
        dec_e_d  = dec_e_q;
        dec_z_d  = dec_z_q;
        dec_x_d  = dec_x_q;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    id_d = grant_id;
                    if (grant_legal) begin
                        state_d = DRIVE;
                        rej_d   = 1'b0;
                        dec_e_d = 1'b0;
                        dec_z_d = mode_sel;
                        dec_x_d = code_sel;
                    end else begin
                        // Rejected requests skip the decoder entirely.
                        state_d = RESP;
                        rej_d   = 1'b1;
                        y_out_d = 16'h0000;
                        y_id_d  = grant_id;
                    end
                end
            end
            DRIVE: begin
                state_d = RESP;
                y_out_d = dec_Y;
                y_id_d  = id_q;
                dec_e_d = 1'b1;
            end
            RESP: begin
                state_d  = IDLE;
                rr_ptr_d = id_q + 2'd1;
            end
            default: begin
                state_d = IDLE;
                dec_e_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= 2'd0;
            id_q     <= 2'd0;
            rej_q    <= 1'b0;
            y_out_q  <= 16'h0000;
            y_id_q   <= 2'd0;
            dec_e_q  <= 1'b1;
            dec_z_q  <= 2'd0;
            dec_x_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            rej_q    <= rej_d;
            y_out_q  <= y_out_d;
            y_id_q   <= y_id_d;
            dec_e_q  <= dec_e_d;
            dec_z_q  <= dec_z_d;
            dec_x_q  <= dec_x_d;
        end
    end

    assign dec_E   = dec_e_q;
    assign dec_Z   = dec_z_q;
    assign dec_X   = dec_x_q;
    assign y_out   = y_out_q;
    assign y_id    = y_id_q;
    assign y_valid = (state_q == RESP);
    assign err     = (state_q == RESP) && rej_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_decoder_arbiter.sv
// Bench for decoder_arbiter: behavioural one-hot decoder, response scoreboard
// and one task per scenario.
module tb_decoder_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [7:0]  mode_in = 8'd0;
    logic [15:0] code_in = 16'd0;
    logic [3:0]  ack;
    logic        dec_E;
    logic [1:0]  dec_Z;
    logic [3:0]  dec_X;
    logic [15:0] dec_Y;
    logic [15:0] y_out;
    logic        y_valid;
    logic [1:0]  y_id;
    logic        err;
    logic        busy;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] y;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   resp_count = 0;
    int   cyc = 0;
    int   last_resp_cyc = 0;

    localparam logic [31:0] RST_VEC = {4'b0000, 1'b1, 27'd0};

    decoder_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mode_in (mode_in),
        .code_in (code_in),
        .ack     (ack),
        .dec_E   (dec_E),
        .dec_Z   (dec_Z),
        .dec_X   (dec_X),
        .dec_Y   (dec_Y),
        .y_out   (y_out),
        .y_valid (y_valid),
        .y_id    (y_id),
        .err     (err),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // External decoder: one-hot of the code, truncated to the mode's input width.
    always_comb begin
        dec_Y = 16'h0000;
        if (!dec_E) begin
            case (dec_Z)
                2'b00:   dec_Y = 16'h0001 << dec_X[1:0];
                2'b01:   dec_Y = 16'h0001 << dec_X[2:0];
                2'b10:   dec_Y = 16'h0001 << dec_X;
                default: dec_Y = 16'h0000;
            endcase
        end
    end

    // Response monitor: pops the scoreboard on every y_valid pulse.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] ack_exp;
        if (y_valid === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_resp: got id=%0d y_out=%h err=%b ack=%b, required no response",
                         y_id, y_out, err, ack);
            end else begin
                e = exp_q.pop_front();
                ack_exp = 4'b0001 << e.id;
                $display("[TB] resp id=%0d y_out=%h err=%b ack=%b", y_id, y_out, err, ack);
                if ({y_id, y_out, err, ack} !== {e.id, e.y, e.err, ack_exp}) begin
                    tests_failed++;
                    $display("FAIL resp_fields: got id=%0d y_out=%h err=%b ack=%b, required id=%0d y_out=%h err=%b ack=%b",
                             y_id, y_out, err, ack, e.id, e.y, e.err, ack_exp);
                end
            end
            resp_count++;
            last_resp_cyc = cyc;
        end else begin
            tests_run++;
            if (ack !== 4'b0000 || err !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_pulses: got ack=%b err=%b, required ack=0000 err=0", ack, err);
            end
        end
    end

    task automatic set_fields(input int i, input logic [1:0] m, input logic [3:0] c);
        mode_in[2*i +: 2] = m;
        code_in[4*i +: 4] = c;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [15:0] y, input logic e);
        exp_t x;
        x.id = id; x.y = y; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_resp(input int target, input string name);
        int n = 0;
        while (resp_count < target && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (resp_count < target) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_timeout: got %0d responses, required %0d", name, resp_count, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if ({ack, dec_E, dec_Z, dec_X, y_out, y_valid, y_id, err, busy} !== RST_VEC) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, required %h",
                     {ack, dec_E, dec_Z, dec_X, y_out, y_valid, y_id, err, busy}, RST_VEC);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_fields(0, 2'b01, 4'b0101);
        req = 4'b0001;
        push_exp(2'd0, 16'h0020, 1'b0);
        @(negedge clk);
        #1;
        tests_run++;
        if ({busy, dec_E, dec_Z, dec_X, y_valid} !== {1'b1, 1'b0, 2'b01, 4'b0101, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_drive: got busy=%b E=%b Z=%b X=%b y_valid=%b, required 1 0 01 0101 0",
                     busy, dec_E, dec_Z, dec_X, y_valid);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({y_valid, dec_E} !== 2'b11) begin
            tests_failed++;
            $display("FAIL single_latency: got y_valid=%b E=%b, required 1 1", y_valid, dec_E);
        end
        req = 4'b0000;
        @(negedge clk);
        #1;
        tests_run++;
        if ({busy, y_out, y_id, dec_Z, dec_X} !== {1'b0, 16'h0020, 2'd0, 2'b01, 4'b0101}) begin
            tests_failed++;
            $display("FAIL single_hold: got busy=%b y_out=%h y_id=%0d Z=%b X=%b, required 0 0020 0 01 0101",
                     busy, y_out, y_id, dec_Z, dec_X);
        end
    endtask

    task automatic test_round_robin();
        int start_cyc;
        int base;
        do_reset();
        for (int i = 0; i < 4; i++) set_fields(i, 2'b10, 4'(i));
        for (int i = 0; i < 5; i++) push_exp(2'(i % 4), 16'h0001 << (i % 4), 1'b0);
        base = resp_count;
        start_cyc = cyc;
        req = 4'b1111;
        wait_resp(base + 5, "round_robin");
        req = 4'b0000;
        tests_run++;
        if (last_resp_cyc !== start_cyc + 14) begin
            tests_failed++;
            $display("FAIL rr_throughput: got last response at cycle %0d, required %0d",
                     last_resp_cyc, start_cyc + 14);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        set_fields(2, 2'b11, 4'b0001);
        req = 4'b0100;
        push_exp(2'd2, 16'h0000, 1'b1);
        @(negedge clk);
        #1;
        tests_run++;
        if ({y_valid, dec_E} !== 2'b11) begin
            tests_failed++;
            $display("FAIL illegal_latency: got y_valid=%b E=%b, required 1 1", y_valid, dec_E);
        end
        req = 4'b0000;
        @(negedge clk);
        #1;
        tests_run++;
        if ({dec_E, busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL illegal_after: got E=%b busy=%b, required 1 0", dec_E, busy);
        end
    endtask

    task automatic test_out_of_range();
        int base;
        do_reset();
        base = resp_count;
        set_fields(1, 2'b00, 4'b0110);
        req = 4'b0010;
        push_exp(2'd1, 16'h0000, 1'b1);
        wait_resp(base + 1, "oor_reject");
        set_fields(1, 2'b10, 4'b1111);
        push_exp(2'd1, 16'h8000, 1'b0);
        wait_resp(base + 2, "oor_accept");
        req = 4'b0000;
    endtask

    task automatic test_input_change();
        int base;
        do_reset();
        base = resp_count;
        set_fields(0, 2'b10, 4'b0011);
        req = 4'b0001;
        push_exp(2'd0, 16'h0008, 1'b0);
        @(negedge clk);
        #1;
        set_fields(0, 2'b00, 4'b0000);
        req = 4'b0000;
        wait_resp(base + 1, "input_change");
        tests_run++;
        if ({dec_Z, dec_X} !== {2'b10, 4'b0011}) begin
            tests_failed++;
            $display("FAIL input_change_hold: got Z=%b X=%b, required 10 0011", dec_Z, dec_X);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        base = resp_count;
        set_fields(0, 2'b10, 4'b0001);
        set_fields(1, 2'b10, 4'b0010);
        req = 4'b0001;
        push_exp(2'd0, 16'h0002, 1'b0);
        wait_resp(base + 1, "rmid_first");
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0011;
        @(negedge clk);
        #1;
        tests_run++;
        if ({dec_E, dec_X} !== {1'b0, 4'b0010}) begin
            tests_failed++;
            $display("FAIL rmid_rr_grant: got E=%b X=%b, required 0 0010", dec_E, dec_X);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if ({ack, dec_E, dec_Z, dec_X, y_out, y_valid, y_id, err, busy} !== RST_VEC) begin
            tests_failed++;
            $display("FAIL rmid_reset_outputs: got %h, required %h",
                     {ack, dec_E, dec_Z, dec_X, y_out, y_valid, y_id, err, busy}, RST_VEC);
        end
        rst = 1'b0;
        push_exp(2'd0, 16'h0002, 1'b0);
        wait_resp(base + 2, "rmid_regrant");
        req = 4'b0010;
        push_exp(2'd1, 16'h0004, 1'b0);
        wait_resp(base + 3, "rmid_second");
        req = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_illegal();
        test_out_of_range();
        test_input_change();
        test_reset_mid();
        repeat (5) @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending responses, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decoder_arbiter.md
DECODER_ARBITER -- requirements
Module: decoder_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 req  in  4  per-requester request; bit i = requester i.
REQ-005 mode_in  in  8  2-bit decode mode per requester; requester i at [2i+1:2i].
REQ-006 code_in  in  16  4-bit code per requester; requester i at [4i+3:4i].
REQ-007 ack  out  4  one-hot, one-cycle completion pulse to the granted requester.
REQ-008 dec_E  out  1  decoder enable, active-low (1 = decoder disabled).
REQ-009 dec_Z  out  2  decoder mode select.
REQ-010 dec_X  out  4  decoder input code.
REQ-011 dec_Y  in  16  one-hot decoder result, combinational from dec_E/dec_Z/dec_X.
REQ-012 y_out  out  16  registered decode result of the completed transaction.
REQ-013 y_valid  out  1  one-cycle pulse; y_out, y_id and err are valid.
REQ-014 y_id  out  2  requester index of the completed transaction.
REQ-015 err  out  1  set with y_valid when the request was rejected.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, DRIVE and RESP.
REQ-018 In IDLE with req != 0, the block SHALL grant the first set req bit at or after rr_ptr (2-bit round-robin pointer), searching upward modulo 4, and latch that requester's id, mode and code.
REQ-019 Mode legality: mode 00 legal for code 0-3; mode 01 legal for code 0-7; mode 10 legal for code 0-15; mode 11 always illegal.
REQ-020 Legal grant: IDLE->DRIVE; in DRIVE, dec_E=0 and dec_Z/dec_X SHALL equal the latched mode/code (registered outputs, stable for the whole cycle).
REQ-021 At the end of DRIVE, dec_Y SHALL be sampled into y_out; DRIVE->RESP.
REQ-022 Illegal grant: IDLE->RESP directly; the decoder SHALL NOT be enabled; y_out=0 and err=1.
REQ-023 In RESP: y_valid=1, ack[id]=1, y_id=id; rr_ptr <= id+1 (mod 4); RESP->IDLE unconditionally.
REQ-024 Latency: request seen in IDLE at cycle N -> y_valid/ack at N+2 (legal) or N+1 (illegal); maximum throughput is one grant per 3 cycles.
REQ-025 dec_E SHALL be 1 in IDLE and RESP, and dec_Z/dec_X SHALL hold their last values outside DRIVE.
REQ-026 Changes to req, mode_in or code_in after the grant SHALL NOT affect the in-flight transaction; deasserting req mid-transaction SHALL NOT cancel it.
REQ-027 A requester SHALL hold req until ack; req still high in the IDLE cycle after ack counts as a new request and arbitrates under the advanced rr_ptr.
REQ-028 y_out and y_id SHALL hold until the next RESP; y_valid, err and ack SHALL be zero outside RESP.
REQ-029 With all four requesters continuously requesting, grants SHALL rotate 0,1,2,3,0,... and no requester SHALL wait more than 3 other grants.

Reset
REQ-030 With rst=1 at a clock edge, the state SHALL become IDLE and rr_ptr 0, with these outputs: ack=0, dec_E=1, dec_Z=0, dec_X=0, y_out=0, y_valid=0, y_id=0, err=0, busy=0.
REQ-031 Reset asserted in DRIVE or RESP SHALL abort the transaction with no ack or y_valid; the requester SHALL re-arbitrate after reset is released.

Verification
REQ-032 Single request: rst released, req=0001, mode0=01, code0=0101 -> DRIVE shows dec_E=0, dec_Z=01, dec_X=0101; 2 cycles after the grant, y_valid=1, y_out=0x0020, y_id=0, ack=0001, err=0.
REQ-033 Round-robin: req=1111 held with all requesters in legal mode 10 and code=i -> y_id sequence 0,1,2,3,0, with y_out=0x0001,0x0002,0x0004,0x0008.
REQ-034 Illegal request: req=0100, mode2=11 -> y_valid 1 cycle after the grant, err=1, y_out=0, y_id=2, dec_E stays 1 throughout.
REQ-035 Out-of-range request: mode1=00, code1=0110 -> err=1; then mode1=10, code1=1111 -> y_out=0x8000, err=0.
REQ-036 Input change mid-transaction: code0 changed from 0011 to 0000 during DRIVE, with mode0=10 -> y_out=0x0008 (latched value used).
REQ-037 Reset mid-transaction: rst pulsed during DRIVE -> no ack or y_valid, all outputs at reset values, next grant goes to the lowest set req bit.
